// File: rtl/fft_frame_sequencer_pkg.sv
// Shared constants and state encoding for the FFT frame sequencer and its frame buffers.
package fft_frame_sequencer_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int N_POINTS   = 8;
    localparam int IDX_W      = 3;
    localparam int TMO_W      = 8;

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_WRITE  = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fft_frame_buffer.sv
// N-entry complex register file: serial indexed write or full parallel load,
// with every entry exposed on a flattened parallel read bus.
module fft_frame_buffer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = N_POINTS,
    parameter int IW = IDX_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [DW-1:0]   wr_real,
    input  logic [DW-1:0]   wr_imag,
    input  logic            ld_en,
    input  logic [N*DW-1:0] ld_real,
    input  logic [N*DW-1:0] ld_imag,
    output logic [N*DW-1:0] par_real,
    output logic [N*DW-1:0] par_imag
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic [DW-1:0] real_reg;
            logic [DW-1:0] imag_reg;

            // A parallel load takes priority; the two write modes are never used together.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    real_reg <= '0;
                    imag_reg <= '0;
                end else if (ld_en) begin
                    real_reg <= ld_real[gi*DW +: DW];
                    imag_reg <= ld_imag[gi*DW +: DW];
                end else if (wr_en && (wr_idx == IW'(gi))) begin
                    real_reg <= wr_real;
                    imag_reg <= wr_imag;
                end
            end

            assign par_real[gi*DW +: DW] = real_reg;
            assign par_imag[gi*DW +: DW] = imag_reg;
        end
    endgenerate

endmodule

// File: rtl/fft_frame_sequencer.sv
// Gathers a frame of complex samples, drives the FFT write/start/ready handshake,
// then streams the captured bins back out one per beat.
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int N       = N_POINTS,
    parameter int TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_real,
    input  logic [DW-1:0]   in_imag,
    output logic            fft_write,
    output logic            fft_start,
    input  logic            fft_ready,
    output logic [N*DW-1:0] fft_in_real,
    output logic [N*DW-1:0] fft_in_imag,
    input  logic [N*DW-1:0] fft_out_real,
    input  logic [N*DW-1:0] fft_out_imag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_real,
    output logic [DW-1:0]   out_imag,
    output logic [2:0]      out_index,
    output logic            out_last,
    output logic            busy,
    output logic            frame_err,
    output logic [15:0]     frame_count
);

    localparam int IW = IDX_W;
    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);

    seq_state_t        state_reg, state_next;
    logic [IW-1:0]     wr_idx_reg, wr_idx_next;
    logic [IW-1:0]     rd_idx_reg, rd_idx_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [15:0]       frame_count_reg, frame_count_next;

    logic              smp_wr;
    logic              res_ld;
    logic              fft_write_raw;
    logic              fft_start_raw;
    logic [N*DW-1:0]   res_par_real;
    logic [N*DW-1:0]   res_par_imag;
    logic [DW-1:0]     res_real_arr [N];
    logic [DW-1:0]     res_imag_arr [N];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= S_LOAD;
            wr_idx_reg      <= '0;
            rd_idx_reg      <= '0;
            tmo_reg         <= '0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wr_idx_reg      <= wr_idx_next;
            rd_idx_reg      <= rd_idx_next;
            tmo_reg         <= tmo_next;
            frame_count_reg <= frame_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wr_idx_next      = wr_idx_reg;
        rd_idx_next      = rd_idx_reg;
        tmo_next         = tmo_reg;
        frame_count_next = frame_count_reg;
        in_ready         = 1'b0;
        fft_write_raw    = 1'b0;
        fft_start_raw    = 1'b0;
        out_valid        = 1'b0;
        frame_err        = 1'b0;
        smp_wr           = 1'b0;
        res_ld           = 1'b0;

        case (state_reg)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    smp_wr      = 1'b1;
                    wr_idx_next = wr_idx_reg + IW'(1);
                    if (wr_idx_reg == LAST_IDX) begin
                        wr_idx_next = '0;
                        state_next  = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                fft_write_raw = 1'b1;
                state_next    = S_START;
            end
            S_START: begin
                fft_start_raw = 1'b1;
                tmo_next      = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // Ready is only trusted here, so a level left over from the previous frame is ignored.
                if (fft_ready) begin
                    res_ld     = 1'b1;
                    state_next = S_UNLOAD;
                end else if (tmo_reg == TMO_MAX) begin
                    frame_err   = 1'b1;
                    wr_idx_next = '0;
                    state_next  = S_LOAD;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_idx_next = rd_idx_reg + IW'(1);
                    if (rd_idx_reg == LAST_IDX) begin
                        rd_idx_next      = '0;
                        frame_count_next = frame_count_reg + 16'd1;
                        state_next       = S_LOAD;
                    end
                end
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    fft_frame_buffer #(.DW(DW), .N(N), .IW(IW)) u_sample_buf (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (smp_wr),
        .wr_idx   (wr_idx_reg),
        .wr_real  (in_real),
        .wr_imag  (in_imag),
        .ld_en    (1'b0),
        .ld_real  ('0),
        .ld_imag  ('0),
        .par_real (fft_in_real),
        .par_imag (fft_in_imag)
    );

    fft_frame_buffer #(.DW(DW), .N(N), .IW(IW)) u_result_buf (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_real  ('0),
        .wr_imag  ('0),
        .ld_en    (res_ld),
        .ld_real  (fft_out_real),
        .ld_imag  (fft_out_imag),
        .par_real (res_par_real),
        .par_imag (res_par_imag)
    );

    // Indexed read of the result buffer; rd_idx only moves on a transfer, so stalls hold the beat.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_res_unpack
            assign res_real_arr[gi] = res_par_real[gi*DW +: DW];
            assign res_imag_arr[gi] = res_par_imag[gi*DW +: DW];
        end
    endgenerate

    assign out_real    = res_real_arr[rd_idx_reg];
    assign out_imag    = res_imag_arr[rd_idx_reg];
    assign out_index   = rd_idx_reg;
    assign out_last    = out_valid && (rd_idx_reg == LAST_IDX);
    assign busy        = (state_reg != S_LOAD);
    assign frame_count = frame_count_reg;
    assign fft_write   = fft_write_raw && !RST;
    assign fft_start   = fft_start_raw && !RST;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: sequencer against a stub FFT whose result k is (re+256k, im-re)
// and whose ready delay is programmable (negative = never ready).
module tb_fft_frame_sequencer;

    localparam int DW = 16;
    localparam int N  = 8;

    logic            CLK;
    logic            RST;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_real;
    logic [DW-1:0]   in_imag;
    logic            fft_write;
    logic            fft_start;
    logic            fft_ready;
    logic [N*DW-1:0] fft_in_real;
    logic [N*DW-1:0] fft_in_imag;
    logic [N*DW-1:0] fft_out_real;
    logic [N*DW-1:0] fft_out_imag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_real;
    logic [DW-1:0]   out_imag;
    logic [2:0]      out_index;
    logic            out_last;
    logic            busy;
    logic            frame_err;
    logic [15:0]     frame_count;

    int n_chk;
    int n_pass;
    int stub_delay;
    int stub_cnt;
    logic stub_armed;
    logic [N*DW-1:0] stub_in_real;
    logic [N*DW-1:0] stub_in_imag;
    int src_re [8];
    int src_im [8];
    int exp_re [8];
    int exp_im [8];

    fft_frame_sequencer #(.DW(DW), .N(N), .TIMEOUT(64)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .fft_write    (fft_write),
        .fft_start    (fft_start),
        .fft_ready    (fft_ready),
        .fft_in_real  (fft_in_real),
        .fft_in_imag  (fft_in_imag),
        .fft_out_real (fft_out_real),
        .fft_out_imag (fft_out_imag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stub FFT: latches inputs on write, raises ready stub_delay cycles after start.
    always @(posedge CLK) begin
        if (RST) begin
            fft_ready    <= 1'b0;
            stub_armed   <= 1'b0;
            stub_cnt     <= 0;
            stub_in_real <= '0;
            stub_in_imag <= '0;
        end else begin
            if (fft_write) begin
                stub_in_real <= fft_in_real;
                stub_in_imag <= fft_in_imag;
                fft_ready    <= 1'b0;
                stub_armed   <= 1'b0;
            end
            if (fft_start) begin
                stub_armed <= 1'b1;
                stub_cnt   <= 0;
            end else if (stub_armed && !fft_ready) begin
                if (stub_delay >= 0 && stub_cnt >= stub_delay)
                    fft_ready <= 1'b1;
                else
                    stub_cnt <= stub_cnt + 1;
            end
        end
    end

    always_comb begin
        fft_out_real = '0;
        fft_out_imag = '0;
        for (int k = 0; k < N; k++) begin
            fft_out_real[k*DW +: DW] = stub_in_real[k*DW +: DW] + 16'(256 * k);
            fft_out_imag[k*DW +: DW] = stub_in_imag[k*DW +: DW] - stub_in_real[k*DW +: DW];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int count);
        int cyc;
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_real  = 16'(src_re[i]);
            in_imag  = 16'(src_im[i]);
            cyc = 0;
            while (!in_ready && cyc < 300) begin
                step();
                cyc++;
            end
            if (cyc >= 300) chk("in_ready_timeout", int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input int stall);
        int cyc;
        for (int k = 0; k < N; k++) begin
            out_ready = (stall != 0) ? 1'b0 : 1'b1;
            cyc = 0;
            while (!out_valid && cyc < 300) begin
                step();
                cyc++;
            end
            chk("out_valid", int'(out_valid), 1);
            chk("out_index", int'(out_index), k);
            chk("out_real", int'($signed(out_real)), exp_re[k]);
            chk("out_imag", int'($signed(out_imag)), exp_im[k]);
            chk("out_last", int'(out_last), (k == N - 1) ? 1 : 0);
            if (stall != 0) begin
                repeat (2) begin
                    step();
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_index", int'(out_index), k);
                    chk("hold_real", int'($signed(out_real)), exp_re[k]);
                    chk("hold_imag", int'($signed(out_imag)), exp_im[k]);
                end
                out_ready = 1'b1;
            end
            $display("beat k=%0d re=%0d im=%0d last=%0d", out_index,
                     $signed(out_real), $signed(out_imag), out_last);
            step();
        end
        out_ready = 1'b1;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) begin
            src_re[k] = k;
            src_im[k] = 0;
            exp_re[k] = 257 * k;
            exp_im[k] = -k;
        end
    endtask

    initial begin
        int cyc;
        int n;
        n_chk      = 0;
        n_pass     = 0;
        RST        = 1'b1;
        in_valid   = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        out_ready  = 1'b1;
        stub_delay = 0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fft_write", int'(fft_write), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_out_real", int'(out_real), 0);
        chk("rst_fft_in", int'(fft_in_real[3*DW +: DW]), 0);

        // 1: ramp with latency checks
        load_ramp();
        send(N);
        chk("lat_fft_write", int'(fft_write), 1);
        chk("lat_in_ready", int'(in_ready), 0);
        chk("fft_in3_real", int'($signed(fft_in_real[3*DW +: DW])), 3);
        step();
        chk("lat_fft_start", int'(fft_start), 1);
        chk("lat_busy", int'(busy), 1);
        step();
        step();
        chk("lat_fft_ready", int'(fft_ready), 1);
        chk("lat_no_valid_yet", int'(out_valid), 0);
        step();
        chk("lat_out_valid", int'(out_valid), 1);
        recv(0);
        chk("ramp_frame_count", int'(frame_count), 1);
        chk("ramp_in_ready", int'(in_ready), 1);

        // 2: impulse
        for (int k = 0; k < N; k++) begin
            src_re[k] = (k == 0) ? 1 : 0;
            src_im[k] = 0;
            exp_re[k] = (k == 0) ? 1 : 256 * k;
            exp_im[k] = (k == 0) ? -1 : 0;
        end
        send(N);
        recv(0);
        chk("imp_frame_count", int'(frame_count), 2);

        // 3: backpressure
        for (int k = 0; k < N; k++) begin
            src_re[k] = 100 - 3 * k;
            src_im[k] = 2 * k;
            exp_re[k] = 100 + 253 * k;
            exp_im[k] = 5 * k - 100;
        end
        stub_delay = 3;
        send(N);
        recv(1);
        chk("bp_frame_count", int'(frame_count), 3);

        // 4: timeout, then recovery
        stub_delay = -1;
        load_ramp();
        send(N);
        cyc = 0;
        while (!fft_start && cyc < 10) begin
            step();
            cyc++;
        end
        chk("tmo_saw_start", int'(fft_start), 1);
        n = 0;
        while (!frame_err && n < 200) begin
            step();
            n++;
        end
        $display("timeout frame_err after %0d cycles", n);
        chk("tmo_cycles", n, 64);
        chk("tmo_no_valid", int'(out_valid), 0);
        step();
        chk("tmo_err_single", int'(frame_err), 0);
        chk("tmo_in_ready", int'(in_ready), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_frame_count", int'(frame_count), 3);
        stub_delay = 0;
        send(N);
        recv(0);
        chk("post_tmo_frame_count", int'(frame_count), 4);

        // 5: reset mid-load
        send(5);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_frame_count", int'(frame_count), 0);
        send(N);
        recv(0);
        chk("post_rst_frame_count", int'(frame_count), 1);

        // 6: back-to-back frames with in_valid held high
        RST = 1'b1;
        step();
        RST = 1'b0;
        out_ready = 1'b1;
        fork
            begin : src_proc
                int scyc;
                for (int j = 0; j < 3 * N; j++) begin
                    in_valid = 1'b1;
                    in_real  = 16'(10 * (j / N) + (j % N) + 1);
                    in_imag  = 16'((j % N) - (j / N));
                    scyc = 0;
                    while (!in_ready && scyc < 300) begin
                        step();
                        scyc++;
                    end
                    if (scyc >= 300) chk("b2b_in_ready_timeout", int'(in_ready), 1);
                    step();
                end
                in_valid = 1'b0;
            end
            begin : sink_proc
                int kcyc;
                int re;
                int im;
                for (int j = 0; j < 3 * N; j++) begin
                    kcyc = 0;
                    while (!out_valid && kcyc < 300) begin
                        step();
                        kcyc++;
                    end
                    re = 10 * (j / N) + (j % N) + 1;
                    im = (j % N) - (j / N);
                    chk("b2b_valid", int'(out_valid), 1);
                    chk("b2b_index", int'(out_index), j % N);
                    chk("b2b_real", int'($signed(out_real)), re + 256 * (j % N));
                    chk("b2b_imag", int'($signed(out_imag)), im - re);
                    $display("b2b beat j=%0d k=%0d re=%0d im=%0d", j, out_index,
                             $signed(out_real), $signed(out_imag));
                    step();
                end
            end
        join
        chk("b2b_frame_count", int'(frame_count), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
